// File: rtl/dmem_if.sv
// Load/store request and response bundle between the core and dmem_responder.
// Optional DMEM_BYTE_STROBE_EN adds the req_be byte-enable lane.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  req_be;
`endif
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

`ifdef DMEM_BYTE_STROBE_EN
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a LATENCY wait-state counter.
// Optional macro DMEM_BYTE_STROBE_EN enables per-byte store enables (req_be).
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic clk,
    input  logic reset,
    dmem_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WLOAD   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  be_q, be_d;
`endif

    logic          accept;
    logic          commit;
    logic          cmt_we;
    logic          cmt_err;
    logic [31:0]   cmt_addr;
    logic [31:0]   cmt_wdata;
    logic [3:0]    cmt_be;
    logic [AW-1:0] cmt_idx;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_L);
    endfunction

    assign bus.req_ready  = (state_q == IDLE) && !reset;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // With zero latency the commit happens on the accept edge, so it must use the live inputs.
    always_comb begin
        if (state_q == IDLE) begin
            cmt_we    = bus.req_we;
            cmt_addr  = bus.req_addr;
            cmt_wdata = bus.req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
            cmt_be    = bus.req_be;
`else
            cmt_be    = 4'hF;
`endif
        end else begin
            cmt_we    = we_q;
            cmt_addr  = addr_q;
            cmt_wdata = wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
            cmt_be    = be_q;
`else
            cmt_be    = 4'hF;
`endif
        end
        cmt_err = addr_err(cmt_addr);
        cmt_idx = cmt_addr[AW+1:2];
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
        be_d    = be_q;
`endif
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
                    be_d    = bus.req_be;
`endif
                    if (LATENCY == 0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        wcnt_d  = WLOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = cmt_err;
            rdata_d = (cmt_we || cmt_err) ? 32'h0 : mem[cmt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wcnt_q  <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= 4'h0;
`endif
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= be_d;
`endif
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; a reset edge suppresses any in-flight store.
    always_ff @(posedge clk) begin
        if (commit && cmt_we && !cmt_err && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (cmt_be[i]) begin
                    mem[cmt_idx][8*i +: 8] <= cmt_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the far end of the core's load/store port. It serves the address, store data and load data paths for integer lw/sw and floating-point flw/fsw traffic. It accepts one request at a time through a valid/ready handshake and models a configurable access latency with a wait-state counter. It returns load data or an error flag with a one-cycle response pulse, and is the block the datapath's memory interface connects to in multi-cycle and pipelined builds.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the storage array (power of two, 16..4096)
LATENCY, 2, wait-state cycles between request accept and memory commit (0..15)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request this cycle
req_we  in  1  1 = store (sw/fsw), 0 = load (lw/flw)
req_addr  in  32  byte address
req_wdata  in  32  store data
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load data; 0 for stores and errors
resp_err  out  1  request was misaligned or out of range

Behaviour:
- Clock is clk. Reset is reset, synchronous and active-high; it is sampled only on the rising edge of clk.
- States: IDLE, WAIT, RESP. A down-counter wcnt is 4 bits wide.
- Reset values:
  - state IDLE, wcnt 0
  - resp_valid 0, resp_rdata 0, resp_err 0
  - captured request registers 0
  - memory array contents are not reset
- req_ready is combinational and equals (state==IDLE) && !reset.
- Accept: a request is accepted at a rising edge where req_valid && req_ready. At that edge req_we, req_addr and req_wdata are captured. The inputs are ignored at all other times, and req_valid may drop after acceptance.
- Error check, made on the captured address:
  - err = (addr[1:0] != 0) || (addr[31:2] >= DEPTH_WORDS)
  - An erroring request performs no write and no read.
- Transitions:
  - IDLE, accept with LATENCY==0: go to RESP. The commit happens on the accept edge.
  - IDLE, accept with LATENCY>0: go to WAIT, wcnt = LATENCY-1.
  - WAIT, wcnt!=0: decrement wcnt.
  - WAIT, wcnt==0: commit, then go to RESP.
  - RESP: go to IDLE unconditionally.
- Commit:
  - Store without error: mem[addr[31:2]] is written with the captured wdata.
  - Load without error: resp_rdata is registered from mem[addr[31:2]].
  - Store or error: resp_rdata = 0.
  - resp_err is registered from err.
- resp_valid is 1 exactly during the RESP cycle. resp_rdata and resp_err hold their values until the next commit.
- Timing: if accept is at edge N, commit is at edge N+LATENCY and resp_valid is high in the cycle after that edge. Throughput is one request per LATENCY+2 cycles.
- There is no response backpressure; the requester must sample on resp_valid.
- Read-after-write: a load issued after a store's response observes the stored data. Write-first ordering is guaranteed because only one request is ever outstanding.
- Reset mid-operation: a pending request in WAIT is dropped. It produces no write and no response. A store already committed remains in memory.
- Address bits above log2(DEPTH_WORDS)+1 must be zero, otherwise resp_err is set. There is no aliasing or wrap-around.

Optional Feature:
DMEM_BYTE_STROBE_EN
- Defined: adds input port req_be [3:0] after req_wdata, captured at accept.
  - A store writes only the bytes where req_be[i]=1 (byte i = bits 8i+7:8i).
  - req_be==0 is a legal no-op store that still responds with resp_err=0.
  - Loads ignore req_be and return the full word.
  - The alignment check is unchanged, so the address must still be word-aligned.
- Undefined: the req_be port is absent and every store writes the full 32-bit word.

Test Plan:
- Reset for 2 cycles, then release → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=0 while reset=1.
- LATENCY=2: store 0x3F800000 to 0x10 accepted at edge N → resp_valid pulse in the cycle after edge N+2, resp_err=0, resp_rdata=0; req_ready=0 for 3 cycles.
- After that store, load from 0x10 → resp_rdata=0x3F800000, resp_err=0, with the same 3-cycle spacing.
- Load from 0x12 (misaligned) and from 0x400 with DEPTH_WORDS=256 (out of range) → resp_err=1, resp_rdata=0; word 0x10 still reads back 0x3F800000.
- Store 0xDEADBEEF to 0x20, then assert reset while in WAIT → no resp_valid; a later load from 0x20 returns its prior contents. With LATENCY=0 the bench also checks that resp_valid follows accept by exactly 1 cycle.
- DMEM_BYTE_STROBE_EN: word 0x20 = 0x11223344, store 0xAABBCCDD with req_be=4'b0101 → a load returns 0x11BB33DD.
